rv_decode_stage: RTL and testbench
==================================

RV_DECODE_STAGE -- requirements
Module: rv_decode_stage

Interface
REQ-001 Parameter XLEN, default 32: datapath width of the instruction, PC and immediate.
REQ-002 Parameter RESET_PC_TAG, default 32'h0000_0000: reset value of pc_o.
REQ-003 clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 in_valid  in  1  fetch presents a word.
REQ-006 in_ready  out  1  stage accepts the word.
REQ-007 instr_i  in  32  raw RV32I instruction.
REQ-008 pc_i  in  XLEN  instruction address.
REQ-009 flush_i  in  1  discard all held and incoming words.
REQ-010 out_valid  out  1  decoded bundle valid.
REQ-011 out_ready  in  1  execute accepts the bundle.
REQ-012 pc_o  out  XLEN  PC of the bundle.
REQ-013 rd_o, rs1_o, rs2_o  out  5 each  register indices.
REQ-014 imm_o  out  XLEN  sign-extended immediate.
REQ-015 alu_op_o  out  4  alu_op_t; reg_write_o, mem_read_o, mem_write_o, branch_o, jump_o, alu_src_imm_o  out  1 each.
REQ-016 illegal_o  out  1  bundle came from an unsupported encoding.

Function
REQ-017 The stage SHALL decode ADD, SUB, AND, OR, XOR, SLL, SLT, SLTU, SRL, SRA, ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI (f3=001), SRLI, SRAI, LW, SW, BEQ, JAL, JALR and LUI per the RV32I base encoding.
REQ-018 Immediates: I {inst[31:20]}; S {inst[31:25],inst[11:7]}; B {inst[31],inst[7],inst[30:25],inst[11:8],0}; J {inst[31],inst[19:12],inst[20],inst[30:21],0}; U {inst[31:12],12'b0}; each sign-extended from its top bit to XLEN; shift-immediates output shamt zero-extended.
REQ-019 Latency SHALL be exactly one cycle: a word accepted in cycle N appears at the outputs with out_valid=1 in cycle N+1 when the output is empty or draining.
REQ-020 Buffering SHALL be a 2-entry skid: output register plus one skid register; in_ready SHALL be a registered signal equal to "skid empty".
REQ-021 Transfer occurs only on valid&&ready at each port; while out_valid=1 and out_ready=0 every output SHALL hold stable.
REQ-022 Sustained in_valid=out_ready=1 SHALL give one bundle per cycle with no bubbles.
REQ-023 Output stalled, skid empty, input accepted: word SHALL go to skid, in_ready falls next cycle.
REQ-024 Output consumed while skid full: skid SHALL move to output next cycle and in_ready SHALL rise; order SHALL be preserved (FIFO).
REQ-025 flush_i=1 SHALL clear out_valid and the skid next cycle, drop any word offered that cycle, and set in_ready=1; flush has priority over every simultaneous handshake.
REQ-026 Writes to rd=x0 SHALL produce reg_write_o=0.
REQ-027 Unsupported opcode/funct3/funct7 combinations SHALL be handled per REQ-031/REQ-032.

Reset
REQ-028 On reset assertion, immediately and without clock: out_valid=0, skid empty, in_ready=0 while reset is high, then in_ready=1 on the first clock after release.
REQ-029 Reset values: pc_o=RESET_PC_TAG; all other data/control outputs 0; alu_op_o=ALU_ADD.
REQ-030 Reset mid-transfer SHALL discard both entries; no partial bundle is ever emitted.

Configuration
REQ-031 With ILLEGAL_DETECT_EN defined, unsupported encodings SHALL emit a bundle with illegal_o=1 and all write/mem/branch/jump controls 0, plus a saturating 16-bit illegal counter readable by hierarchy.
REQ-032 Without ILLEGAL_DETECT_EN, illegal_o SHALL be tied 0, the counter absent, and unsupported encodings decoded as ADDI x0,x0,0.

Structure
REQ-033 Opcode, funct3 and funct7 constants, alu_op_t enum and the decoded-bundle struct SHALL live in shared package rv_isa_pkg.
REQ-034 Combinational decode SHALL be sub-module rv_decode_comb; rv_decode_stage holds only the skid/handshake logic.

Verification
REQ-035 0x002081B3 (add x3,x1,x2), out_ready=1 -> next cycle rd=3, rs1=1, rs2=2, alu_op=ADD, reg_write=1.
REQ-036 0xFFF00293 (addi x5,x0,-1) -> imm_o=0xFFFFFFFF, alu_src_imm=1, rd=5.
REQ-037 0xFE208CE3 (beq x1,x2,-8) then 0x0020A423 (sw x2,8(x1)) -> imm_o=0xFFFFFFF8 branch=1; then imm_o=8, mem_write=1, reg_write=0.
REQ-038 Stream 4 words, out_ready low 3 cycles mid-stream -> in_ready drops after 2 held, all 4 delivered in order, no duplicates.
REQ-039 flush_i with skid full and in_valid=1 -> next cycle out_valid=0, in_ready=1, none of the 3 words emitted.
REQ-040 0xFFFFFFFF -> illegal_o=1 with ILLEGAL_DETECT_EN; addi x0 bundle, illegal_o=0 without.

Source files
------------

// File: rtl/rv_isa_pkg.sv
// ----------------------------------------------------------------------------
// rv_isa_pkg
// Shared RV32I decode definitions: opcode/funct3/funct7 constants, the ALU
// operation enum and the decoded-bundle struct handed from the combinational
// decoder to the decode stage registers.
// The immediate and PC travel beside the bundle because they are XLEN wide,
// while this struct holds only the fixed-width fields.
// Optional feature macro used by the importing files: ILLEGAL_DETECT_EN.
// ----------------------------------------------------------------------------
package rv_isa_pkg;

    // Major opcodes (inst[6:0])
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    // funct3 (inst[14:12])
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_WORD    = 3'b010;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_JALR    = 3'b000;

    // funct7 (inst[31:25])
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_op_t;

    typedef struct packed {
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        alu_op_t    alu_op;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic       alu_src_imm;
        logic       illegal;
    } dec_bundle_t;

    // funct3 -> ALU op for OP / OP-IMM; alt selects SUB / SRA.
    function automatic alu_op_t alu_op_from_f3(input logic [2:0] f3, input logic alt);
        alu_op_t op;
        case (f3)
            F3_ADD_SUB: op = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:     op = ALU_SLL;
            F3_SLT:     op = ALU_SLT;
            F3_SLTU:    op = ALU_SLTU;
            F3_XOR:     op = ALU_XOR;
            F3_SRL_SRA: op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:      op = ALU_OR;
            default:    op = ALU_AND;
        endcase
        return op;
    endfunction

    // ADDI x0,x0,0 : what an unsupported encoding collapses to.
    function automatic dec_bundle_t nop_bundle();
        dec_bundle_t b;
        b             = '0;
        b.alu_op      = ALU_ADD;
        b.alu_src_imm = 1'b1;
        return b;
    endfunction

endpackage

// File: rtl/rv_decode_stage_if.sv
// ----------------------------------------------------------------------------
// rv_decode_stage_if
// Bundles the fetch-side handshake (in_valid/in_ready, instr_i, pc_i,
// flush_i) and the execute-side handshake plus decoded fields
// (out_valid/out_ready, pc_o, rd/rs1/rs2, imm, alu_op, control bits).
//   master : the environment (fetch + execute)
//   slave  : rv_decode_stage
// ----------------------------------------------------------------------------
interface rv_decode_stage_if #(
    parameter int XLEN = 32
);
    import rv_isa_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instr_i;
    logic [XLEN-1:0] pc_i;
    logic            flush_i;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] pc_o;
    logic [4:0]      rd_o;
    logic [4:0]      rs1_o;
    logic [4:0]      rs2_o;
    logic [XLEN-1:0] imm_o;
    alu_op_t         alu_op_o;
    logic            reg_write_o;
    logic            mem_read_o;
    logic            mem_write_o;
    logic            branch_o;
    logic            jump_o;
    logic            alu_src_imm_o;
    logic            illegal_o;

    modport master (
        output in_valid, instr_i, pc_i, flush_i, out_ready,
        input  in_ready, out_valid, pc_o, rd_o, rs1_o, rs2_o, imm_o, alu_op_o,
               reg_write_o, mem_read_o, mem_write_o, branch_o, jump_o,
               alu_src_imm_o, illegal_o
    );

    modport slave (
        input  in_valid, instr_i, pc_i, flush_i, out_ready,
        output in_ready, out_valid, pc_o, rd_o, rs1_o, rs2_o, imm_o, alu_op_o,
               reg_write_o, mem_read_o, mem_write_o, branch_o, jump_o,
               alu_src_imm_o, illegal_o
    );
endinterface

// File: rtl/rv_decode_comb.sv
// ----------------------------------------------------------------------------
// rv_decode_comb
// Purely combinational RV32I decoder for the supported subset.
// Ports:
//   instr_i : raw 32-bit instruction
//   dec_o   : decoded register indices, ALU op and control bits
//   imm_o   : immediate sign-extended to XLEN (shift amounts zero-extended)
// Macro ILLEGAL_DETECT_EN: when defined, unsupported encodings set
// dec_o.illegal; otherwise they decode as ADDI x0,x0,0 with illegal clear.
// Register fields an instruction format does not use are driven as 0.
// ----------------------------------------------------------------------------
module rv_decode_comb
    import rv_isa_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr_i,
    output dec_bundle_t     dec_o,
    output logic [XLEN-1:0] imm_o
);

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm32;
    logic        legal;
    logic        is_shift;

    assign opc      = instr_i[6:0];
    assign f3       = instr_i[14:12];
    assign f7       = instr_i[31:25];
    assign is_shift = (f3 == F3_SLL) || (f3 == F3_SRL_SRA);

    always_comb begin
        dec_o = nop_bundle();
        imm32 = '0;
        legal = 1'b0;
        case (opc)
            OPC_OP: begin
                legal = (f7 == F7_BASE) ||
                        ((f7 == F7_ALT) && ((f3 == F3_ADD_SUB) || (f3 == F3_SRL_SRA)));
                dec_o.rd          = instr_i[11:7];
                dec_o.rs1         = instr_i[19:15];
                dec_o.rs2         = instr_i[24:20];
                dec_o.alu_op      = alu_op_from_f3(f3, f7[5]);
                dec_o.alu_src_imm = 1'b0;
                dec_o.reg_write   = 1'b1;
            end
            OPC_OP_IMM: begin
                if (f3 == F3_SLL)
                    legal = (f7 == F7_BASE);
                else if (f3 == F3_SRL_SRA)
                    legal = (f7 == F7_BASE) || (f7 == F7_ALT);
                else
                    legal = 1'b1;
                dec_o.rd        = instr_i[11:7];
                dec_o.rs1       = instr_i[19:15];
                // Only shifts use funct7 to pick the arithmetic variant;
                // for ADDI bit 30 is part of the immediate.
                dec_o.alu_op    = alu_op_from_f3(f3, (f3 == F3_SRL_SRA) && f7[5]);
                dec_o.reg_write = 1'b1;
                imm32 = is_shift ? {27'b0, instr_i[24:20]}
                                 : {{20{instr_i[31]}}, instr_i[31:20]};
            end
            OPC_LOAD: begin
                legal           = (f3 == F3_WORD);
                dec_o.rd        = instr_i[11:7];
                dec_o.rs1       = instr_i[19:15];
                dec_o.mem_read  = 1'b1;
                dec_o.reg_write = 1'b1;
                imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
            end
            OPC_STORE: begin
                legal           = (f3 == F3_WORD);
                dec_o.rs1       = instr_i[19:15];
                dec_o.rs2       = instr_i[24:20];
                dec_o.mem_write = 1'b1;
                imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            end
            OPC_BRANCH: begin
                legal             = (f3 == F3_BEQ);
                dec_o.rs1         = instr_i[19:15];
                dec_o.rs2         = instr_i[24:20];
                dec_o.alu_op      = ALU_SUB;
                dec_o.alu_src_imm = 1'b0;
                dec_o.branch      = 1'b1;
                imm32 = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25],
                         instr_i[11:8], 1'b0};
            end
            OPC_JAL: begin
                legal           = 1'b1;
                dec_o.rd        = instr_i[11:7];
                dec_o.jump      = 1'b1;
                dec_o.reg_write = 1'b1;
                imm32 = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20],
                         instr_i[30:21], 1'b0};
            end
            OPC_JALR: begin
                legal           = (f3 == F3_JALR);
                dec_o.rd        = instr_i[11:7];
                dec_o.rs1       = instr_i[19:15];
                dec_o.jump      = 1'b1;
                dec_o.reg_write = 1'b1;
                imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
            end
            OPC_LUI: begin
                legal           = 1'b1;
                dec_o.rd        = instr_i[11:7];
                dec_o.reg_write = 1'b1;
                imm32 = {instr_i[31:12], 12'b0};
            end
            default: legal = 1'b0;
        endcase

        if (!legal) begin
            dec_o = nop_bundle();
            imm32 = '0;
`ifdef ILLEGAL_DETECT_EN
            dec_o.illegal = 1'b1;
`endif
        end

        // x0 is hard-wired; never request a write to it.
        if (dec_o.rd == 5'd0)
            dec_o.reg_write = 1'b0;
    end

    assign imm_o = XLEN'($signed(imm32));

endmodule

// File: rtl/rv_decode_stage.sv
// ----------------------------------------------------------------------------
// rv_decode_stage
// One-cycle decode stage with a 2-entry skid buffer (output register + skid
// register) between fetch and execute.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : rv_decode_stage_if.slave (fetch and execute handshakes, decoded
//           outputs)
// in_ready is a flop equal to "skid empty", so fetch never sees a
// combinational path from out_ready.
// Macro ILLEGAL_DETECT_EN: when defined, illegal_o reports unsupported
// encodings and illegal_cnt_q counts accepted illegal words (saturating).
// ----------------------------------------------------------------------------
module rv_decode_stage
    import rv_isa_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_PC_TAG = XLEN'(32'h0000_0000)
) (
    input logic               clk,
    input logic               reset,
    rv_decode_stage_if.slave  bus
);

    dec_bundle_t     dec;
    logic [XLEN-1:0] dec_imm;

    rv_decode_comb #(.XLEN(XLEN)) u_decode (
        .instr_i (bus.instr_i),
        .dec_o   (dec),
        .imm_o   (dec_imm)
    );

    logic            in_ready_q,  in_ready_d;
    logic            out_valid_q, out_valid_d;
    dec_bundle_t     out_bndl_q,  out_bndl_d;
    logic [XLEN-1:0] out_pc_q,    out_pc_d;
    logic [XLEN-1:0] out_imm_q,   out_imm_d;
    logic            skid_valid_q, skid_valid_d;
    dec_bundle_t     skid_bndl_q,  skid_bndl_d;
    logic [XLEN-1:0] skid_pc_q,    skid_pc_d;
    logic [XLEN-1:0] skid_imm_q,   skid_imm_d;
    logic            accept;

    assign accept = bus.in_valid && in_ready_q && !bus.flush_i;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_bndl_d   = out_bndl_q;
        out_pc_d     = out_pc_q;
        out_imm_d    = out_imm_q;
        skid_valid_d = skid_valid_q;
        skid_bndl_d  = skid_bndl_q;
        skid_pc_d    = skid_pc_q;
        skid_imm_d   = skid_imm_q;

        if (bus.flush_i) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || bus.out_ready) begin
            // Output slot frees this cycle: the older skid word goes first.
            // A skid word and a new accept cannot coexist, since in_ready_q
            // is low whenever the skid is occupied.
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_bndl_d   = skid_bndl_q;
                out_pc_d     = skid_pc_q;
                out_imm_d    = skid_imm_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_valid_d = 1'b1;
                out_bndl_d  = dec;
                out_pc_d    = bus.pc_i;
                out_imm_d   = dec_imm;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            // Output stalled: park the new word in the skid.
            skid_valid_d = 1'b1;
            skid_bndl_d  = dec;
            skid_pc_d    = bus.pc_i;
            skid_imm_d   = dec_imm;
        end

        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            out_bndl_q   <= '0;
            out_pc_q     <= RESET_PC_TAG;
            out_imm_q    <= '0;
        end else begin
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            out_bndl_q   <= out_bndl_d;
            out_pc_q     <= out_pc_d;
            out_imm_q    <= out_imm_d;
        end
    end

    // Skid payload is only meaningful while skid_valid_q is set.
    always_ff @(posedge clk) begin
        skid_bndl_q <= skid_bndl_d;
        skid_pc_q   <= skid_pc_d;
        skid_imm_q  <= skid_imm_d;
    end

`ifdef ILLEGAL_DETECT_EN
    logic [15:0] illegal_cnt_q, illegal_cnt_d;

    always_comb begin
        illegal_cnt_d = illegal_cnt_q;
        if (accept && dec.illegal && (illegal_cnt_q != 16'hFFFF))
            illegal_cnt_d = illegal_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            illegal_cnt_q <= '0;
        else
            illegal_cnt_q <= illegal_cnt_d;
    end
`endif

    assign bus.in_ready      = in_ready_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.pc_o          = out_pc_q;
    assign bus.imm_o         = out_imm_q;
    assign bus.rd_o          = out_bndl_q.rd;
    assign bus.rs1_o         = out_bndl_q.rs1;
    assign bus.rs2_o         = out_bndl_q.rs2;
    assign bus.alu_op_o      = out_bndl_q.alu_op;
    assign bus.reg_write_o   = out_bndl_q.reg_write;
    assign bus.mem_read_o    = out_bndl_q.mem_read;
    assign bus.mem_write_o   = out_bndl_q.mem_write;
    assign bus.branch_o      = out_bndl_q.branch;
    assign bus.jump_o        = out_bndl_q.jump;
    assign bus.alu_src_imm_o = out_bndl_q.alu_src_imm;
`ifdef ILLEGAL_DETECT_EN
    assign bus.illegal_o     = out_bndl_q.illegal;
`else
    assign bus.illegal_o     = 1'b0;
`endif

endmodule

// File: tb/tb_rv_decode_stage.sv
// ----------------------------------------------------------------------------
// tb_rv_decode_stage
// Directed bench for rv_decode_stage. Inputs change on the falling edge,
// outputs are sampled on the falling edge (half a cycle after the DUT's
// rising edge). Honours ILLEGAL_DETECT_EN for the illegal-word check.
// ----------------------------------------------------------------------------
module tb_rv_decode_stage;
    import rv_isa_pkg::*;

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    rv_decode_stage_if #(.XLEN(32)) bus ();

    rv_decode_stage #(.XLEN(32), .RESET_PC_TAG(32'h0000_0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic ordy, input logic fl);
        bus.in_valid  = v;
        bus.instr_i   = ins;
        bus.pc_i      = pc;
        bus.out_ready = ordy;
        bus.flush_i   = fl;
    endtask

    // addi xk,x0,k
    function automatic logic [31:0] addi_k(input int k);
        return (32'(k) << 20) | (32'(k) << 7) | 32'h13;
    endfunction

    logic [31:0] exp_illegal;

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // ---- reset state ----
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
        chk("rst_pc",        bus.pc_o,           32'h0);
        chk("rst_alu_op",    32'(bus.alu_op_o),  32'(ALU_ADD));
        chk("rst_ctrl", {26'b0, bus.reg_write_o, bus.mem_read_o, bus.mem_write_o,
                         bus.branch_o, bus.jump_o, bus.alu_src_imm_o}, 32'd0);
        chk("rst_imm",       bus.imm_o,          32'h0);
        reset = 1'b0;
        @(negedge clk);
        chk("rel_in_ready",  32'(bus.in_ready),  32'd1);

        // ---- streaming decode, out_ready=1 ----
        drive(1'b1, 32'h002081B3, 32'h100, 1'b1, 1'b0);   // add x3,x1,x2
        @(negedge clk);
        chk("add_valid", 32'(bus.out_valid), 32'd1);
        chk("add_pc",    bus.pc_o,  32'h100);
        chk("add_rd",    32'(bus.rd_o),  32'd3);
        chk("add_rs1",   32'(bus.rs1_o), 32'd1);
        chk("add_rs2",   32'(bus.rs2_o), 32'd2);
        chk("add_alu",   32'(bus.alu_op_o), 32'(ALU_ADD));
        chk("add_wr",    32'(bus.reg_write_o), 32'd1);
        chk("add_src",   32'(bus.alu_src_imm_o), 32'd0);

        drive(1'b1, 32'hFFF00293, 32'h104, 1'b1, 1'b0);   // addi x5,x0,-1
        @(negedge clk);
        chk("addi_valid", 32'(bus.out_valid), 32'd1);
        chk("addi_imm",   bus.imm_o, 32'hFFFF_FFFF);
        chk("addi_src",   32'(bus.alu_src_imm_o), 32'd1);
        chk("addi_rd",    32'(bus.rd_o), 32'd5);
        chk("addi_wr",    32'(bus.reg_write_o), 32'd1);

        drive(1'b1, 32'hFE208CE3, 32'h108, 1'b1, 1'b0);   // beq x1,x2,-8
        @(negedge clk);
        chk("beq_imm",    bus.imm_o, 32'hFFFF_FFF8);
        chk("beq_branch", 32'(bus.branch_o), 32'd1);
        chk("beq_wr",     32'(bus.reg_write_o), 32'd0);
        chk("beq_alu",    32'(bus.alu_op_o), 32'(ALU_SUB));

        drive(1'b1, 32'h0020A423, 32'h10C, 1'b1, 1'b0);   // sw x2,8(x1)
        @(negedge clk);
        chk("sw_imm",  bus.imm_o, 32'h8);
        chk("sw_mw",   32'(bus.mem_write_o), 32'd1);
        chk("sw_wr",   32'(bus.reg_write_o), 32'd0);
        chk("sw_rs2",  32'(bus.rs2_o), 32'd2);

        drive(1'b1, 32'h402081B3, 32'h110, 1'b1, 1'b0);   // sub x3,x1,x2
        @(negedge clk);
        chk("sub_alu", 32'(bus.alu_op_o), 32'(ALU_SUB));

        drive(1'b1, 32'h4030D293, 32'h114, 1'b1, 1'b0);   // srai x5,x1,3
        @(negedge clk);
        chk("srai_alu", 32'(bus.alu_op_o), 32'(ALU_SRA));
        chk("srai_imm", bus.imm_o, 32'h3);

        drive(1'b1, 32'h12345537, 32'h118, 1'b1, 1'b0);   // lui x10,0x12345
        @(negedge clk);
        chk("lui_imm", bus.imm_o, 32'h1234_5000);
        chk("lui_rd",  32'(bus.rd_o), 32'd10);

        drive(1'b1, 32'h00208033, 32'h11C, 1'b1, 1'b0);   // add x0,x1,x2
        @(negedge clk);
        chk("x0_wr", 32'(bus.reg_write_o), 32'd0);

        drive(1'b1, 32'hFFFF_FFFF, 32'h120, 1'b1, 1'b0);  // unsupported
        @(negedge clk);
`ifdef ILLEGAL_DETECT_EN
        exp_illegal = 32'd1;
`else
        exp_illegal = 32'd0;
`endif
        chk("ill_valid", 32'(bus.out_valid), 32'd1);
        chk("ill_flag",  32'(bus.illegal_o), exp_illegal);
        chk("ill_ctrl", {27'b0, bus.reg_write_o, bus.mem_read_o, bus.mem_write_o,
                         bus.branch_o, bus.jump_o}, 32'd0);
        chk("ill_rd",    32'(bus.rd_o), 32'd0);
        chk("ill_imm",   bus.imm_o, 32'h0);

        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        chk("drain_valid", 32'(bus.out_valid), 32'd0);

        // ---- stall mid-stream: 4 words, out_ready low 3 cycles ----
        drive(1'b1, addi_k(1), 32'h200, 1'b1, 1'b0);
        @(negedge clk);
        chk("st_w0_pc", bus.pc_o, 32'h200);
        drive(1'b1, addi_k(2), 32'h204, 1'b0, 1'b0);      // W1 -> skid
        @(negedge clk);
        chk("st_hold1_pc",  bus.pc_o, 32'h200);
        chk("st_in_ready0", 32'(bus.in_ready), 32'd0);
        drive(1'b1, addi_k(3), 32'h208, 1'b0, 1'b0);      // refused
        @(negedge clk);
        chk("st_hold2_pc",  bus.pc_o, 32'h200);
        chk("st_hold2_imm", bus.imm_o, 32'h1);
        chk("st_in_ready1", 32'(bus.in_ready), 32'd0);
        drive(1'b1, addi_k(3), 32'h208, 1'b0, 1'b0);
        @(negedge clk);
        chk("st_hold3_pc",  bus.pc_o, 32'h200);
        drive(1'b1, addi_k(3), 32'h208, 1'b1, 1'b0);      // W0 out, skid -> out
        @(negedge clk);
        chk("st_w1_pc",     bus.pc_o, 32'h204);
        chk("st_w1_imm",    bus.imm_o, 32'h2);
        chk("st_in_ready2", 32'(bus.in_ready), 32'd1);
        drive(1'b1, addi_k(3), 32'h208, 1'b1, 1'b0);
        @(negedge clk);
        chk("st_w2_pc", bus.pc_o, 32'h208);
        drive(1'b1, addi_k(4), 32'h20C, 1'b1, 1'b0);
        @(negedge clk);
        chk("st_w3_pc", bus.pc_o, 32'h20C);
        chk("st_w3_rd", 32'(bus.rd_o), 32'd4);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        chk("st_end_valid", 32'(bus.out_valid), 32'd0);

        // ---- flush with skid full and a word offered ----
        drive(1'b1, addi_k(5), 32'h300, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, addi_k(6), 32'h304, 1'b0, 1'b0);
        @(negedge clk);
        chk("fl_skid_full", 32'(bus.in_ready), 32'd0);
        drive(1'b1, addi_k(7), 32'h308, 1'b1, 1'b1);
        @(negedge clk);
        chk("fl_out_valid", 32'(bus.out_valid), 32'd0);
        chk("fl_in_ready",  32'(bus.in_ready),  32'd1);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        chk("fl_no_emit", 32'(bus.out_valid), 32'd0);

        // ---- async reset mid-transfer ----
        drive(1'b1, addi_k(8), 32'h400, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, addi_k(9), 32'h404, 1'b0, 1'b0);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("ar_out_valid", 32'(bus.out_valid), 32'd0);
        chk("ar_in_ready",  32'(bus.in_ready),  32'd0);
        chk("ar_pc",        bus.pc_o, 32'h0);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("ar_rel_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        chk("ar_no_emit",   32'(bus.out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
